// File: rtl/fifo_pkg.sv
// Shared types and constants for the fifo_top write-side arbitration logic.
package fifo_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int ARB_MAX_REQ = 8;

  typedef enum logic {
    IDLE,
    BURST
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping mod NUM_REQ.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  logic [NUM_REQ-1:0] rotated;
  logic [IDX_W-1:0]   offset;

  // rotated[0] is the request at ptr, so the lowest set bit is the winner's distance from ptr
  always_comb begin
    rotated = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int j;
      j = i + int'(ptr);
      if (j >= NUM_REQ) j = j - NUM_REQ;
      rotated[i] = req[j];
    end
  end

  always_comb begin
    int k;
    offset = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) offset = IDX_W'(i);
    end
    k = int'(ptr) + int'(offset);
    if (k >= NUM_REQ) k = k - NUM_REQ;
    idx = IDX_W'(k);
  end

  assign any = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked sharing of the fifo_top write port among NUM_REQ producers.
// state | meaning
// IDLE  | no owner; registers the next round-robin winner
// BURST | owner drives the FIFO write port until last beat, valid drop or burst cap
module fifo_wr_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter  int MAX_BURST  = 4,
  localparam int IDX_W      = $clog2(NUM_REQ),
  localparam int CNT_W      = $clog2(MAX_BURST + 1)
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_push,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          busy
);

  import fifo_pkg::*;

  arb_state_e            state, state_nxt;
  logic [IDX_W-1:0]      owner, owner_nxt;
  logic [IDX_W-1:0]      rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]      win_idx;
  logic [CNT_W-1:0]      beat_cnt, beat_cnt_nxt;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] owner_data;
  logic                  win_any;
  logic                  owner_valid;
  logic                  owner_last;
  logic                  accept;
  logic                  at_cap;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req (req_valid),
    .ptr (rr_ptr),
    .any (win_any),
    .idx (win_idx)
  );

  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == IDX_W'(i)) begin
        owner_valid = req_valid[i];
        owner_last  = req_last[i];
        owner_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign at_cap = (beat_cnt == CNT_W'(MAX_BURST - 1));

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    req_ready    = '0;
    accept       = 1'b0;
    fifo_push    = 1'b0;
    case (state)
      IDLE: begin
        if (win_any) begin
          owner_nxt    = win_idx;
          beat_cnt_nxt = '0;
          state_nxt    = BURST;
        end
      end
      BURST: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          req_ready[i] = (owner == IDX_W'(i)) && !fifo_full;
        end
        accept    = owner_valid && !fifo_full;
        fifo_push = accept;
        if (accept) beat_cnt_nxt = beat_cnt + 1'b1;
        // a full-stalled owner keeps the port; only a dropped valid releases without a beat
        if (!owner_valid || (accept && (owner_last || at_cap))) begin
          state_nxt = IDLE;
          if (owner == IDX_W'(NUM_REQ - 1)) rr_ptr_nxt = '0;
          else                              rr_ptr_nxt = owner + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      wdata_q  <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
      if (fifo_push) wdata_q <= owner_data;
    end
  end

  assign fifo_wdata = fifo_push ? owner_data : wdata_q;
  assign grant_id   = owner;
  assign busy       = (state == BURST);

endmodule
